// File: rtl/bypass_sliced_pipe_pkg.sv
// Shared types, default widths and slice helper for the sliced-PRF operand bypass.
package bypass_sliced_pipe_pkg;

    localparam int ISSUE_WIDTH_DEF = 4;
    localparam int NUM_SLICES_DEF  = 4;
    localparam int SLICE_WIDTH_DEF = 8;
    localparam int PHYS_LOG_DEF    = 7;
    localparam int DATA_WIDTH_DEF  = NUM_SLICES_DEF * SLICE_WIDTH_DEF;

    // Upper bounds understood by slice(); operands wider than these are not supported.
    localparam int SLICE_MAX = 64;
    localparam int DATA_MAX  = 1024;

    // Bypass lane layout for the default configuration: {valid, tag, data}.
    typedef struct packed {
        logic                      valid;
        logic [PHYS_LOG_DEF-1:0]   tag;
        logic [DATA_WIDTH_DEF-1:0] data;
    } bypass_pkt_t;

    function automatic logic [SLICE_MAX-1:0] slice(
        input logic [DATA_MAX-1:0] data,
        input int unsigned         j,
        input int unsigned         width
    );
        logic [DATA_MAX-1:0]  shifted;
        logic [SLICE_MAX-1:0] mask;
        shifted = data >> (j * width);
        mask    = {SLICE_MAX{1'b1}} >> (unsigned'(SLICE_MAX) - width);
        return shifted[SLICE_MAX-1:0] & mask;
    endfunction

endpackage

// File: rtl/bypass_slice_stage.sv
// One stage of the sliced bypass pipe: lane match, slice select and the registers
// that hand the entry to the next stage (absent in the final stage).
module bypass_slice_stage
    import bypass_sliced_pipe_pkg::*;
#(
    parameter int STAGE       = 0,
    parameter int NUM_SLICES  = 4,
    parameter int ISSUE_WIDTH = 4,
    parameter int SLICE_WIDTH = 8,
    parameter int PHYS_LOG    = 7,
    localparam int DATA_WIDTH = NUM_SLICES * SLICE_WIDTH,
    localparam int PKT_WIDTH  = 1 + PHYS_LOG + DATA_WIDTH
)(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush_s,
    input  logic [ISSUE_WIDTH-1:0][PKT_WIDTH-1:0]  bypass_pkt_s,
    input  logic [PHYS_LOG-1:0]                    tag_s,
    input  logic                                   valid_s,
    input  logic                                   prev_matched_s,
    input  logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] slc_s,
    input  logic [SLICE_WIDTH-1:0]                 prf_slice_s,
    output logic                                   hit_s,
    output logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] sel_s,
    output logic [PHYS_LOG-1:0]                    tag_r,
    output logic                                   valid_r,
    output logic                                   prev_matched_r,
    output logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] slc_r
);

    logic [ISSUE_WIDTH-1:0] match_s;
    logic [DATA_WIDTH-1:0]  win_data_s;

    // Per-lane tag compare; later lanes overwrite earlier ones so the highest index wins.
    always_comb begin
        match_s    = '0;
        win_data_s = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            match_s[i] = valid_s && bypass_pkt_s[i][PKT_WIDTH-1]
                         && (bypass_pkt_s[i][DATA_WIDTH +: PHYS_LOG] == tag_s);
            win_data_s = match_s[i] ? bypass_pkt_s[i][DATA_WIDTH-1:0] : win_data_s;
        end
        hit_s = |match_s;
    end

    // Slice select: bypass beats everything, then this stage's PRF slice unless already bypassed.
    always_comb begin
        sel_s = '0;
        for (int j = 0; j < NUM_SLICES; j++) begin
            if (hit_s) begin
                sel_s[j] = SLICE_WIDTH'(slice(DATA_MAX'(win_data_s), unsigned'(j),
                                              unsigned'(SLICE_WIDTH)));
            end else if ((j == STAGE) && !prev_matched_s) begin
                sel_s[j] = prf_slice_s;
            end else begin
                sel_s[j] = slc_s[j];
            end
        end
    end

    generate
        if (STAGE < NUM_SLICES - 1) begin : g_reg
            // Advance the entry; flush drops validity and hit history but keeps data.
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_r          <= '0;
                    valid_r        <= 1'b0;
                    prev_matched_r <= 1'b0;
                    slc_r          <= '0;
                end else begin
                    tag_r          <= tag_s;
                    valid_r        <= valid_s & ~flush_s;
                    prev_matched_r <= (prev_matched_s | hit_s) & ~flush_s;
                    slc_r          <= sel_s;
                end
            end
        end else begin : g_last
            logic unused_s;
            assign unused_s       = ^{clk, reset, flush_s};
            assign tag_r          = '0;
            assign valid_r        = 1'b0;
            assign prev_matched_r = 1'b0;
            assign slc_r          = '0;
        end
    endgenerate

endmodule

// File: rtl/bypass_sliced_pipe.sv
// Operand bypass for a PRF read in NUM_SLICES staggered slices: assembles the
// operand over a NUM_SLICES-deep pipe while snooping every bypass lane.
module bypass_sliced_pipe
    import bypass_sliced_pipe_pkg::*;
#(
    parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
    parameter int NUM_SLICES  = NUM_SLICES_DEF,
    parameter int SLICE_WIDTH = SLICE_WIDTH_DEF,
    parameter int PHYS_LOG    = PHYS_LOG_DEF,
    localparam int DATA_WIDTH = NUM_SLICES * SLICE_WIDTH,
    localparam int PKT_WIDTH  = 1 + PHYS_LOG + DATA_WIDTH
)(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ISSUE_WIDTH-1:0][PKT_WIDTH-1:0]  bypassPacket_i,
    input  logic [PHYS_LOG-1:0]                    phySrc_i,
    input  logic                                   srcValid_i,
    input  logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] prfSlice_i,
    input  logic                                   flush_i,
    output logic [DATA_WIDTH-1:0]                  data_o,
    output logic                                   valid_o,
    output logic                                   bypassHit_o
);

    logic [PHYS_LOG-1:0]                    tag_s      [NUM_SLICES];
    logic                                   valid_s    [NUM_SLICES];
    logic                                   prev_s     [NUM_SLICES];
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] slc_s      [NUM_SLICES];
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] sel_s      [NUM_SLICES];
    logic                                   hit_s      [NUM_SLICES];
    logic [PHYS_LOG-1:0]                    nxt_tag_s  [NUM_SLICES];
    logic                                   nxt_valid_s[NUM_SLICES];
    logic                                   nxt_prev_s [NUM_SLICES];
    logic [NUM_SLICES-1:0][SLICE_WIDTH-1:0] nxt_slc_s  [NUM_SLICES];
    logic                                   unused_s;

    assign tag_s[0]   = phySrc_i;
    assign valid_s[0] = srcValid_i;
    assign prev_s[0]  = 1'b0;
    assign slc_s[0]   = prfSlice_i;

    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_stage
        bypass_slice_stage #(
            .STAGE       (s),
            .NUM_SLICES  (NUM_SLICES),
            .ISSUE_WIDTH (ISSUE_WIDTH),
            .SLICE_WIDTH (SLICE_WIDTH),
            .PHYS_LOG    (PHYS_LOG)
        ) u_stage (
            .clk            (clk),
            .reset          (reset),
            .flush_s        (flush_i),
            .bypass_pkt_s   (bypassPacket_i),
            .tag_s          (tag_s[s]),
            .valid_s        (valid_s[s]),
            .prev_matched_s (prev_s[s]),
            .slc_s          (slc_s[s]),
            .prf_slice_s    (prfSlice_i[s]),
            .hit_s          (hit_s[s]),
            .sel_s          (sel_s[s]),
            .tag_r          (nxt_tag_s[s]),
            .valid_r        (nxt_valid_s[s]),
            .prev_matched_r (nxt_prev_s[s]),
            .slc_r          (nxt_slc_s[s])
        );
        if (s < NUM_SLICES - 1) begin : g_link
            assign tag_s[s+1]   = nxt_tag_s[s];
            assign valid_s[s+1] = nxt_valid_s[s];
            assign prev_s[s+1]  = nxt_prev_s[s];
            assign slc_s[s+1]   = nxt_slc_s[s];
        end
    end

    // The final stage has no successor, so its register outputs are tied off.
    assign unused_s = ^{nxt_tag_s[NUM_SLICES-1], nxt_valid_s[NUM_SLICES-1],
                        nxt_prev_s[NUM_SLICES-1], nxt_slc_s[NUM_SLICES-1]};

    // Flush kills the entry leaving this cycle combinationally.
    assign valid_o     = valid_s[NUM_SLICES-1] & ~flush_i;
    assign bypassHit_o = prev_s[NUM_SLICES-1] | hit_s[NUM_SLICES-1];
    assign data_o      = sel_s[NUM_SLICES-1];

endmodule

// File: tb/tb_bypass_sliced_pipe.sv
// Directed bench for bypass_sliced_pipe at NUM_SLICES = 4, 1 and 8.
module tb_bypass_sliced_pipe;
    import bypass_sliced_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // NUM_SLICES = 4 (default) instance
    logic [3:0][39:0] bp4;
    logic [6:0]       src4;
    logic             sv4, fl4;
    logic [3:0][7:0]  prf4;
    logic [31:0]      d4;
    logic             v4, h4;

    // NUM_SLICES = 1 instance
    logic [3:0][15:0] bp1;
    logic [6:0]       src1;
    logic             sv1, fl1;
    logic [0:0][7:0]  prf1;
    logic [7:0]       d1;
    logic             v1, h1;

    // NUM_SLICES = 8 instance
    logic [3:0][71:0] bp8;
    logic [6:0]       src8;
    logic             sv8, fl8;
    logic [7:0][7:0]  prf8;
    logic [63:0]      d8;
    logic             v8, h8;

    int total = 0;
    int bad   = 0;
    int n_match;

    bypass_sliced_pipe dut4 (
        .clk(clk), .reset(reset), .bypassPacket_i(bp4), .phySrc_i(src4),
        .srcValid_i(sv4), .prfSlice_i(prf4), .flush_i(fl4),
        .data_o(d4), .valid_o(v4), .bypassHit_o(h4));

    bypass_sliced_pipe #(.NUM_SLICES(1)) dut1 (
        .clk(clk), .reset(reset), .bypassPacket_i(bp1), .phySrc_i(src1),
        .srcValid_i(sv1), .prfSlice_i(prf1), .flush_i(fl1),
        .data_o(d1), .valid_o(v1), .bypassHit_o(h1));

    bypass_sliced_pipe #(.NUM_SLICES(8), .SLICE_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .bypassPacket_i(bp8), .phySrc_i(src8),
        .srcValid_i(sv8), .prfSlice_i(prf8), .flush_i(fl8),
        .data_o(d8), .valid_o(v8), .bypassHit_o(h8));

    function automatic logic [39:0] pk4(input logic v, input logic [6:0] t, input logic [31:0] d);
        bypass_pkt_t p;
        p.valid = v;
        p.tag   = t;
        p.data  = d;
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, outputs checked 4ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp4 = '0; src4 = '0; sv4 = 1'b0; fl4 = 1'b0; prf4 = '0;
        bp1 = '0; src1 = '0; sv1 = 1'b0; fl1 = 1'b0; prf1 = '0;
        bp8 = '0; src8 = '0; sv8 = 1'b0; fl8 = 1'b0; prf8 = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #4;
        chk("rst_valid4", 64'(v4), 64'h0);
        chk("rst_hit4",   64'(h4), 64'h0);
        chk("rst_data4",  64'(d4), 64'h0);
        chk("rst_valid1", 64'(v1), 64'h0);
        chk("rst_valid8", 64'(v8), 64'h0);
        chk("rst_data8",  d8,      64'h0);

        // No bypass: PRF slices arrive one per cycle
        tick(); src4 = 7'h12; sv4 = 1'b1; prf4 = 32'h0000_0011;
        #4 chk("nobyp_t0_valid", 64'(v4), 64'h0);
        tick(); src4 = '0; sv4 = 1'b0; prf4 = 32'h0000_2200;
        tick(); prf4 = 32'h0033_0000;
        #4 chk("nobyp_t2_valid", 64'(v4), 64'h0);
        tick(); prf4 = 32'h4400_0000;
        #4;
        chk("nobyp_data",  64'(d4), 64'h4433_2211);
        chk("nobyp_valid", 64'(v4), 64'h1);
        chk("nobyp_hit",   64'(h4), 64'h0);
        tick(); prf4 = '0;
        #4 chk("nobyp_after_valid", 64'(v4), 64'h0);

        // Stage-1 hit on lane 2
        tick(); src4 = 7'h12; sv4 = 1'b1; prf4 = 32'hFFFF_FFFF;
        tick(); src4 = '0; sv4 = 1'b0; bp4[2] = pk4(1'b1, 7'h12, 32'hDEAD_BEEF);
        tick(); bp4 = '0;
        tick();
        #4;
        chk("s1hit_data",  64'(d4), 64'hDEAD_BEEF);
        chk("s1hit_valid", 64'(v4), 64'h1);
        chk("s1hit_hit",   64'(h4), 64'h1);
        tick(); idle_inputs();

        // Stage-3 hit overrides earlier stage-0 hit
        tick(); src4 = 7'h12; sv4 = 1'b1; prf4 = 32'hFFFF_FFFF;
        bp4[0] = pk4(1'b1, 7'h12, 32'h0101_0101);
        tick(); src4 = '0; sv4 = 1'b0; bp4 = '0;
        tick();
        tick(); bp4[3] = pk4(1'b1, 7'h12, 32'hCAFE_F00D);
        #4;
        chk("s3hit_data", 64'(d4), 64'hCAFE_F00D);
        chk("s3hit_hit",  64'(h4), 64'h1);
        tick(); idle_inputs();

        // Dual match at the final stage: highest lane wins
        tick(); src4 = 7'h12; sv4 = 1'b1;
        tick(); src4 = '0; sv4 = 1'b0;
        tick();
        tick();
        bp4[1] = pk4(1'b1, 7'h12, 32'hAAAA_AAAA);
        bp4[3] = pk4(1'b1, 7'h12, 32'hBBBB_BBBB);
        #4;
        n_match = 0;
        for (int i = 0; i < 4; i++) begin
            if (bp4[i][39] && (bp4[i][38:32] == 7'h12)) n_match++;
        end
        if (n_match > 1) $display("note: %0d bypass lanes matched tag 12 in one cycle", n_match);
        chk("dual_data", 64'(d4), 64'hBBBB_BBBB);
        chk("dual_hit",  64'(h4), 64'h1);
        tick(); idle_inputs();

        // Flush: entries at t-1..t+2, flush at t+2, fresh entry at t+3
        tick(); src4 = 7'h20; sv4 = 1'b1; prf4 = 32'h9999_9999;   // t-1
        tick(); src4 = 7'h21;                                      // t
        tick(); src4 = 7'h22;                                      // t+1
        tick(); src4 = 7'h23; fl4 = 1'b1;                          // t+2
        #4 chk("flush_comb_kill", 64'(v4), 64'h0);
        tick(); src4 = 7'h24; fl4 = 1'b0; prf4 = 32'h0000_005A;    // t+3
        #4 chk("flush_t3_valid", 64'(v4), 64'h0);
        tick(); sv4 = 1'b0; src4 = '0; prf4 = 32'h0000_6B00;       // t+4
        #4 chk("flush_t4_valid", 64'(v4), 64'h0);
        tick(); prf4 = 32'h007C_0000;                              // t+5
        #4 chk("flush_t5_valid", 64'(v4), 64'h0);
        tick(); prf4 = 32'h8D00_0000;                              // t+6
        #4;
        chk("flush_t6_valid", 64'(v4), 64'h1);
        chk("flush_t6_data",  64'(d4), 64'h8D7C_6B5A);
        chk("flush_t6_hit",   64'(h4), 64'h0);
        tick(); idle_inputs();

        // Reset mid-flight (with a simultaneous flush, reset wins)
        tick(); src4 = 7'h30; sv4 = 1'b1; prf4 = 32'h1111_1111;   // t
        tick(); src4 = 7'h31; reset = 1'b1; fl4 = 1'b1;            // t+1
        tick(); reset = 1'b0; fl4 = 1'b0; idle_inputs();           // t+2
        #4;
        chk("rst_mid_t2_valid", 64'(v4), 64'h0);
        chk("rst_mid_t2_data",  64'(d4), 64'h0);
        chk("rst_mid_t2_hit",   64'(h4), 64'h0);
        tick();
        #4 chk("rst_mid_t3_valid", 64'(v4), 64'h0);
        tick();
        #4 chk("rst_mid_t4_valid", 64'(v4), 64'h0);

        // NUM_SLICES = 1: fully combinational
        tick(); src1 = 7'h12; sv1 = 1'b1; prf1 = 8'h11;
        #4;
        chk("n1_data",  64'(d1), 64'h11);
        chk("n1_valid", 64'(v1), 64'h1);
        chk("n1_hit",   64'(h1), 64'h0);
        bp1[1] = {1'b1, 7'h12, 8'h5C};
        #1;
        chk("n1_byp_data", 64'(d1), 64'h5C);
        chk("n1_byp_hit",  64'(h1), 64'h1);
        fl1 = 1'b1;
        #1 chk("n1_flush_valid", 64'(v1), 64'h0);
        tick(); idle_inputs();

        // NUM_SLICES = 8: latency 7, 64-bit operand
        tick(); src8 = 7'h12; sv8 = 1'b1; prf8[0] = 8'h01;
        for (int k = 1; k < 8; k++) begin
            tick(); src8 = '0; sv8 = 1'b0; prf8 = '0; prf8[k] = 8'(k + 1);
            #4;
            if (k == 6) chk("n8_t6_valid", 64'(v8), 64'h0);
        end
        chk("n8_data",  d8,      64'h0807_0605_0403_0201);
        chk("n8_valid", 64'(v8), 64'h1);
        chk("n8_hit",   64'(h8), 64'h0);
        tick(); idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
